// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register: owns the PC, assembles one- and
// two-byte instructions into a decode packet, honours stall/flush/redirect.
module if_id_stage #(
   parameter logic [7:0] RESET_VEC_ADDR = 8'h00,
   parameter logic [3:0] LONG_OPC       = 4'hC
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       stall_F,
   input  logic       flush_D,
   input  logic [1:0] pc_sel,
   input  logic [7:0] branch_target,
   input  logic [7:0] mem_pc,
   input  logic [7:0] imem_data,
   output logic [7:0] imem_addr,
   output logic [7:0] instr_D,
   output logic [7:0] imm_D,
   output logic [7:0] pc_D,
   output logic [7:0] pc_plus_1_D,
   output logic       valid_D
);

   typedef enum logic [1:0] {BOOT = 2'd0, FETCH = 2'd1, IMM = 2'd2} state_t;

   state_t     state_q;
   logic [7:0] pc_q, held_op_q, held_pc_q;
   logic [7:0] instr_q, imm_q, pcd_q, pc1d_q;
   logic       valid_q;

   logic [7:0] pc_inc, redir_pc;
   logic       redirect, is_long;

   assign pc_inc    = pc_q + 8'd1;
   assign redirect  = (pc_sel == 2'b01) || (pc_sel == 2'b10);
   assign redir_pc  = (pc_sel == 2'b01) ? branch_target : mem_pc;
   assign is_long   = (imem_data[7:4] == LONG_OPC);
   assign imem_addr = (state_q == BOOT) ? RESET_VEC_ADDR : pc_q;

   assign instr_D     = instr_q;
   assign imm_D       = imm_q;
   assign pc_D        = pcd_q;
   assign pc_plus_1_D = pc1d_q;
   assign valid_D     = valid_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= BOOT;
         pc_q      <= 8'h00;
         held_op_q <= 8'h00;
         held_pc_q <= 8'h00;
         instr_q   <= 8'h00;
         imm_q     <= 8'h00;
         pcd_q     <= 8'h00;
         pc1d_q    <= 8'h00;
         valid_q   <= 1'b0;
      end else if (state_q == BOOT) begin
         pc_q    <= imem_data;
         state_q <= FETCH;
         valid_q <= 1'b0;
      end else if (redirect) begin
         // Wrong-path byte on the bus is squashed along with any held opcode.
         pc_q    <= redir_pc;
         state_q <= FETCH;
         instr_q <= 8'h00;
         imm_q   <= 8'h00;
         pcd_q   <= 8'h00;
         pc1d_q  <= 8'h00;
         valid_q <= 1'b0;
      end else if (flush_D || !stall_F) begin
         pc_q    <= pc_inc;
         instr_q <= 8'h00;
         imm_q   <= 8'h00;
         pcd_q   <= 8'h00;
         pc1d_q  <= 8'h00;
         valid_q <= 1'b0;
         if (state_q == IMM) begin
            state_q <= FETCH;
            if (!flush_D) begin
               instr_q <= held_op_q;
               imm_q   <= imem_data;
               pcd_q   <= held_pc_q;
               pc1d_q  <= pc_inc;
               valid_q <= 1'b1;
            end
         end else if (is_long) begin
            held_op_q <= imem_data;
            held_pc_q <= pc_q;
            state_q   <= IMM;
         end else if (!flush_D) begin
            instr_q <= imem_data;
            pcd_q   <= pc_q;
            pc1d_q  <= pc_inc;
            valid_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: packet-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_if_id_stage;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       stall_F = 1'b0, flush_D = 1'b0;
   logic [1:0] pc_sel = 2'b00;
   logic [7:0] branch_target = 8'h00, mem_pc = 8'h00;
   logic [7:0] imem_data, imem_addr, instr_D, imm_D, pc_D, pc_plus_1_D;
   logic       valid_D;

   logic [7:0] imem [256];
   int         total = 0, passed = 0;

   always #5 clk = ~clk;
   assign imem_data = imem[imem_addr];

   if_id_stage #(.RESET_VEC_ADDR(8'h00), .LONG_OPC(4'hC)) dut (
      .clk(clk), .reset(reset), .stall_F(stall_F), .flush_D(flush_D),
      .pc_sel(pc_sel), .branch_target(branch_target), .mem_pc(mem_pc),
      .imem_data(imem_data), .imem_addr(imem_addr), .instr_D(instr_D),
      .imm_D(imm_D), .pc_D(pc_D), .pc_plus_1_D(pc_plus_1_D), .valid_D(valid_D)
   );

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      else passed++;
   endtask

   // Reference model: tracks the architectural fetch pointer and a pending
   // opcode; emits whole packets rather than mirroring register transfers.
   bit         m_boot, m_pend;
   logic [7:0] m_pc, m_op, m_oppc;
   logic [7:0] e_instr, e_imm, e_pc, e_pc1;
   logic       e_valid;

   task automatic m_emit(input bit v, input logic [7:0] i, input logic [7:0] m,
                         input logic [7:0] p, input logic [7:0] p1);
      e_valid = v; e_instr = v ? i : 8'h00; e_imm = v ? m : 8'h00;
      e_pc = v ? p : 8'h00; e_pc1 = v ? p1 : 8'h00;
   endtask

   always @(posedge clk or posedge reset) begin
      logic [7:0] b;
      if (reset) begin
         m_boot = 1; m_pend = 0; m_pc = 0; m_op = 0; m_oppc = 0;
         m_emit(0, 0, 0, 0, 0);
      end else if (m_boot) begin
         m_pc = imem[8'h00]; m_boot = 0;
         m_emit(0, 0, 0, 0, 0);
      end else if (pc_sel == 2'b01 || pc_sel == 2'b10) begin
         m_pc = (pc_sel == 2'b01) ? branch_target : mem_pc;
         m_pend = 0;
         m_emit(0, 0, 0, 0, 0);
      end else if (flush_D || !stall_F) begin
         b = imem[m_pc];
         if (m_pend) begin
            m_emit(!flush_D, m_op, b, m_oppc, m_pc + 8'd1);
            m_pend = 0;
         end else if (b[7:4] == 4'hC) begin
            m_op = b; m_oppc = m_pc; m_pend = 1;
            m_emit(0, 0, 0, 0, 0);
         end else begin
            m_emit(!flush_D, b, 8'h00, m_pc, m_pc + 8'd1);
         end
         m_pc = m_pc + 8'd1;
      end
   end

   always @(negedge clk) begin
      chk("imem_addr", imem_addr, m_boot ? 8'h00 : m_pc);
      chk("instr_D", instr_D, e_instr);
      chk("imm_D", imm_D, e_imm);
      chk("pc_D", pc_D, e_pc);
      chk("pc_plus_1_D", pc_plus_1_D, e_pc1);
      chk("valid_D", {7'd0, valid_D}, {7'd0, e_valid});
   end

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) @(negedge clk);
      #1;
   endtask

   task automatic rst_begin();
      reset = 1; stall_F = 0; flush_D = 0; pc_sel = 2'b00;
      for (int i = 0; i < 256; i++) imem[i] = 8'h00;
   endtask

   task automatic rst_end();
      @(negedge clk);
      reset = 0;
      #1;
   endtask

   initial begin
      // Boot
      rst_begin();
      imem[8'h00] = 8'h10; imem[8'h10] = 8'h01; imem[8'h11] = 8'h02;
      rst_end();
      chk("boot_addr", imem_addr, 8'h00);
      chk("boot_valid", {7'd0, valid_D}, 8'h00);
      step();
      chk("boot_pc", imem_addr, 8'h10);
      step();
      chk("boot_instr", instr_D, 8'h01);
      chk("boot_pcD", pc_D, 8'h10);
      chk("boot_pc1", pc_plus_1_D, 8'h11);
      chk("boot_vld", {7'd0, valid_D}, 8'h01);

      // Two-byte, stall, flush, redirect vs stall
      rst_begin();
      imem[8'h00] = 8'h10;
      imem[8'h10] = 8'hC4; imem[8'h11] = 8'h5A; imem[8'h12] = 8'h01;
      imem[8'h13] = 8'h02; imem[8'h14] = 8'h03; imem[8'h15] = 8'h04;
      imem[8'h33] = 8'h07;
      rst_end();
      step();
      step();
      chk("two_e1_vld", {7'd0, valid_D}, 8'h00);
      step();
      chk("two_instr", instr_D, 8'hC4);
      chk("two_imm", imm_D, 8'h5A);
      chk("two_pcD", pc_D, 8'h10);
      chk("two_pc1", pc_plus_1_D, 8'h12);
      chk("two_pc", imem_addr, 8'h12);
      stall_F = 1;
      step(3);
      chk("stall_addr", imem_addr, 8'h12);
      chk("stall_instr", instr_D, 8'hC4);
      chk("stall_vld", {7'd0, valid_D}, 8'h01);
      stall_F = 0;
      step();
      chk("resume_instr", instr_D, 8'h01);
      chk("resume_pcD", pc_D, 8'h12);
      step();
      chk("resume2_instr", instr_D, 8'h02);
      flush_D = 1;
      step();
      flush_D = 0;
      chk("flush_vld", {7'd0, valid_D}, 8'h00);
      chk("flush_addr", imem_addr, 8'h15);
      step();
      chk("post_flush_instr", instr_D, 8'h04);
      chk("post_flush_pcD", pc_D, 8'h15);
      stall_F = 1; pc_sel = 2'b10; mem_pc = 8'h33;
      step();
      stall_F = 0; pc_sel = 2'b00;
      chk("rs_addr", imem_addr, 8'h33);
      chk("rs_vld", {7'd0, valid_D}, 8'h00);
      step();
      chk("rs_instr", instr_D, 8'h07);

      // Redirect during IMM
      rst_begin();
      imem[8'h00] = 8'h20; imem[8'h20] = 8'hC4; imem[8'h21] = 8'h11;
      imem[8'h40] = 8'h08;
      rst_end();
      step(2);
      pc_sel = 2'b01; branch_target = 8'h40;
      step();
      pc_sel = 2'b00;
      chk("rimm_vld", {7'd0, valid_D}, 8'h00);
      chk("rimm_addr", imem_addr, 8'h40);
      step();
      chk("rimm_pcD", pc_D, 8'h40);
      chk("rimm_instr", instr_D, 8'h08);
      chk("rimm_imm", imm_D, 8'h00);

      // One-byte op at FF wraps
      rst_begin();
      imem[8'h00] = 8'hFF; imem[8'hFF] = 8'h09;
      rst_end();
      step(2);
      chk("wrap_pcD", pc_D, 8'hFF);
      chk("wrap_pc1", pc_plus_1_D, 8'h00);
      chk("wrap_addr", imem_addr, 8'h00);

      // Two-byte op at FF takes immediate from 00; then reset mid-IMM
      rst_begin();
      imem[8'h00] = 8'hFF; imem[8'hFF] = 8'hC3;
      rst_end();
      step(3);
      chk("wrap2_instr", instr_D, 8'hC3);
      chk("wrap2_imm", imm_D, 8'hFF);
      chk("wrap2_pc1", pc_plus_1_D, 8'h01);
      imem[8'h01] = 8'hC5;
      step();
      chk("pre_rst_addr", imem_addr, 8'h02);
      #2 reset = 1;
      #1;
      chk("rst_vld", {7'd0, valid_D}, 8'h00);
      chk("rst_addr", imem_addr, 8'h00);
      chk("rst_instr", instr_D, 8'h00);
      step(2);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Fetch stage plus IF/ID pipeline register for the 8-bit pipelined processor.
- Owns the PC and drives the instruction-memory address.
- Assembles one-byte instructions, and two-byte instructions (opcode byte followed by an immediate byte), into a single decode-stage packet.
- Feeds the decode stage, whose outputs are then captured by the ID/EX register.
- Honours stall and flush requests from the hazard unit, and PC redirects from the execute/memory stages.

Parameters:
- RESET_VEC_ADDR, 8'h00, imem address holding the boot PC.
- LONG_OPC, 4'hC, value of opcode[7:4] that marks a two-byte instruction.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall_F  in  1  hold PC, FSM and D outputs.
- flush_D  in  1  squash the D outputs to a NOP on the next edge.
- pc_sel  in  2  00: sequential, 01: branch_target, 10: mem_pc, 11: reserved (treated as 00).
- branch_target  in  8  redirect target from execute.
- mem_pc  in  8  return address read from data memory (RET/RTI).
- imem_data  in  8  instruction memory read data (combinational read of imem_addr).
- imem_addr  out  8  instruction memory address.
- instr_D  out  8  opcode byte to decode.
- imm_D  out  8  immediate byte; 0 for one-byte instructions.
- pc_D  out  8  address of the opcode byte.
- pc_plus_1_D  out  8  address following the last byte of the instruction.
- valid_D  out  1  D packet is a real instruction.

Behaviour:
- Reset (asynchronous, active-high): state=BOOT, PC=0, held_op=0, held_pc=0; instr_D, imm_D, pc_D and pc_plus_1_D = 0; valid_D=0.
- imem_addr is combinational: RESET_VEC_ADDR in BOOT, otherwise PC.
- Priority at each edge: reset > redirect (pc_sel 01/10) > flush_D > stall_F > normal.
- BOOT: next edge PC<=imem_data, state<=FETCH, valid_D<=0. Redirect, stall and flush are ignored in BOOT.
- FETCH, normal, imem_data[7:4]!=LONG_OPC (one-byte):
  - instr_D<=imem_data, imm_D<=0, pc_D<=PC, pc_plus_1_D<=PC+1, valid_D<=1.
  - PC<=PC+1.
- FETCH, normal, imem_data[7:4]==LONG_OPC (two-byte):
  - held_op<=imem_data, held_pc<=PC, PC<=PC+1, state<=IMM.
  - D outputs cleared to NOP (all 0, valid_D=0).
- IMM, normal:
  - instr_D<=held_op, imm_D<=imem_data, pc_D<=held_pc, pc_plus_1_D<=PC+1, valid_D<=1.
  - PC<=PC+1, state<=FETCH.
  - Two-byte latency: 2 cycles from opcode fetch to packet.
- Redirect (pc_sel=01 or 10, outside BOOT):
  - PC<=selected target, state<=FETCH, held_op discarded.
  - D outputs cleared (the wrong-path byte is squashed).
  - Overrides stall_F.
- flush_D without redirect: D outputs cleared; PC and state advance as in normal operation, with the fetched byte's packet dropped.
- stall_F: PC, state, held_op/held_pc and all D outputs keep their values; imem_addr stays at PC.
- Arithmetic: all PC arithmetic is mod 256; 8'hFF+1 = 8'h00, including pc_plus_1_D.
- A two-byte opcode at 8'hFF takes its immediate from 8'h00.

Test Plan:
- Boot: imem[0]=8'h10, imem[0x10]=8'h01.
  - Release reset → imem_addr=00 in cycle 1.
  - PC=10 after cycle 1.
  - Next edge: instr_D=01, pc_D=10, pc_plus_1_D=11, valid_D=1.
- Two-byte: imem[0x10]=8'hC4, imem[0x11]=8'h5A.
  - Edge 1: valid_D=0.
  - Edge 2: instr_D=C4, imm_D=5A, pc_D=10, pc_plus_1_D=12, valid_D=1.
  - PC=12 after edge 2.
- Stall: assert stall_F for 3 cycles mid-stream → PC, imem_addr and all D outputs frozen; stream resumes with no byte lost or duplicated.
- Redirect in IMM: after opcode C4 at 0x20, pc_sel=01 with branch_target=8'h40 on the IMM cycle → valid_D=0, PC=40, state=FETCH. The next packet has pc_D=40.
- Redirect vs stall: stall_F=1 and pc_sel=10 with mem_pc=8'h33 on the same edge → PC=33, valid_D=0. Separately, flush_D alone → D outputs cleared while PC advances.
- Wrap and reset: one-byte op at PC=FF → pc_plus_1_D=00 and PC=00. A two-byte op at FF takes its immediate from imem[00]. Asserting reset mid-IMM immediately gives valid_D=0 and state BOOT.
